cache_arbiter: RTL and testbench

Shares the single cache-line physical memory port between the instruction cache and the data cache of the mp4 pipelined CPU. Sits between the two caches and the cacheline adaptor that drives the burst memory interface (`pmem_*`). Accepts at most one line transaction at a time, serialises contending requests with alternating priority, and returns the line to the granted cache with a one-cycle response pulse.

---
 rtl/cache_arbiter.sv | 78 +++++++
 tb/tb_cache_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cache-line memory port between icache and dcache
module cache_arbiter #(
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;
  state_t state, next;
  logic last_grant;
  logic i_pend, d_pend, grant_i, grant_d, serving;
  logic [ADDR_W-1:0] mask;
  assign mask    = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
  assign i_pend  = i_read;
  assign d_pend  = d_read | d_write;
  assign grant_d = state == IDLE && d_pend && (!i_pend || !last_grant);
  assign grant_i = state == IDLE && i_pend && (!d_pend || last_grant);
  assign serving = state == SERVE_I || state == SERVE_D;
  assign i_resp  = state == RESP_I;
  assign d_resp  = state == RESP_D;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  // next-state: grant in IDLE, wait for adaptor, one response cycle
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = grant_d ? SERVE_D : grant_i ? SERVE_I : IDLE;
      SERVE_I: next = mem_resp ? RESP_I : SERVE_I;
      SERVE_D: next = mem_resp ? RESP_D : SERVE_D;
      default: next = IDLE;
    endcase
  end
  // latch the granted transaction, drive memory, capture returned lines
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_grant  <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      if (grant_i || grant_d) begin
        last_grant  <= grant_d;
        mem_address <= (grant_d ? d_address : i_address) & mask;
        mem_read    <= !(grant_d && d_write);
        mem_write   <= grant_d && d_write;
        if (grant_d) mem_wdata <= d_wdata;
      end
      if (serving && mem_resp) begin
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (state == SERVE_I) i_rdata <= mem_rdata;
        if (state == SERVE_D && mem_read) d_rdata <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: table-driven and directed checks of the cache arbiter
module tb_cache_arbiter;
  localparam int LW = 256, AW = 32;
  localparam logic [AW-1:0] AI = 32'h0000_1220, AD = 32'h8000_0040;
  logic clk = 0, rst = 0;
  logic i_read = 0, d_read = 0, d_write = 0, mem_resp = 0;
  logic [AW-1:0] i_address = 32'h0000_1234, d_address = 32'h8000_0047;
  logic [LW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;
  int checks = 0, errors = 0;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    in;
    logic [3:0]    exp;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] in);
    {i_read, d_read, d_write, mem_resp} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " mem_read"}, LW'(mem_read), '0);
    chk({tag, " mem_write"}, LW'(mem_write), '0);
    chk({tag, " i_resp"}, LW'(i_resp), '0);
    chk({tag, " d_resp"}, LW'(d_resp), '0);
  endtask

  task automatic do_reset();
    rst = 0;
    {i_read, d_read, d_write, mem_resp} = 4'b0000;
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    // in = {i_read, d_read, d_write, mem_resp}; exp = {mem_read, mem_write, i_resp, d_resp}
    tbl[0]  = '{4'b1100, 4'b1000, AD};
    tbl[1]  = '{4'b1101, 4'b0001, '0};
    tbl[2]  = '{4'b1100, 4'b0000, '0};
    tbl[3]  = '{4'b1100, 4'b1000, AI};
    tbl[4]  = '{4'b1100, 4'b1000, AI};
    tbl[5]  = '{4'b1101, 4'b0010, '0};
    tbl[6]  = '{4'b0100, 4'b0000, '0};
    tbl[7]  = '{4'b0100, 4'b1000, AD};
    tbl[8]  = '{4'b0101, 4'b0001, '0};
    tbl[9]  = '{4'b0000, 4'b0000, '0};
    tbl[10] = '{4'b0110, 4'b0100, AD};
    tbl[11] = '{4'b0111, 4'b0001, '0};
    tbl[12] = '{4'b0000, 4'b0000, '0};
    tbl[13] = '{4'b0100, 4'b1000, AD};
    tbl[14] = '{4'b0000, 4'b1000, AD};
    tbl[15] = '{4'b0001, 4'b0001, '0};
    tbl[16] = '{4'b0001, 4'b0000, '0};
    tbl[17] = '{4'b0001, 4'b0000, '0};
    tbl[18] = '{4'b0000, 4'b0000, '0};

    #2;
    chk_idle_outputs("reset");
    chk("reset mem_address", LW'(mem_address), '0);
    chk("reset mem_wdata", mem_wdata, '0);
    chk("reset i_rdata", i_rdata, '0);
    chk("reset d_rdata", d_rdata, '0);
    do_reset();

    mem_rdata = {32{8'h3C}};
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].in);
      chk($sformatf("row%0d mem_read", i), LW'(mem_read), LW'(tbl[i].exp[3]));
      chk($sformatf("row%0d mem_write", i), LW'(mem_write), LW'(tbl[i].exp[2]));
      chk($sformatf("row%0d i_resp", i), LW'(i_resp), LW'(tbl[i].exp[1]));
      chk($sformatf("row%0d d_resp", i), LW'(d_resp), LW'(tbl[i].exp[0]));
      if (tbl[i].exp[3] || tbl[i].exp[2])
        chk($sformatf("row%0d mem_address", i), LW'(mem_address), LW'(tbl[i].addr));
    end

    // I-only read, adaptor answers 4 cycles after mem_read rises
    step(4'b1000);
    chk("iread mem_read", LW'(mem_read), 1);
    chk("iread mem_address", LW'(mem_address), LW'(AI));
    repeat (3) step(4'b1000);
    chk("iread hold mem_read", LW'(mem_read), 1);
    mem_rdata = {32{8'hA5}};
    step(4'b1001);
    chk("iread i_resp", LW'(i_resp), 1);
    chk("iread i_rdata", i_rdata, {32{8'hA5}});
    chk("iread d_resp", LW'(d_resp), 0);
    chk("iread mem_read off", LW'(mem_read), 0);
    step(4'b0000);
    chk("iread i_resp pulse", LW'(i_resp), 0);
    chk("iread i_rdata hold", i_rdata, {32{8'hA5}});

    // D write-back: d_rdata keeps the line captured by the table
    d_address = 32'h8000_0040;
    d_wdata = {16{16'h1234}};
    mem_rdata = {32{8'hEE}};
    step(4'b0010);
    chk("dwr mem_write", LW'(mem_write), 1);
    chk("dwr mem_read", LW'(mem_read), 0);
    chk("dwr mem_wdata", mem_wdata, {16{16'h1234}});
    chk("dwr mem_address", LW'(mem_address), LW'(AD));
    step(4'b0011);
    chk("dwr d_resp", LW'(d_resp), 1);
    chk("dwr d_rdata", d_rdata, {32{8'h3C}});
    step(4'b0000);
    chk("dwr d_resp pulse", LW'(d_resp), 0);

    // asynchronous reset in the middle of an I transaction
    step(4'b1000);
    chk("rstmid mem_read", LW'(mem_read), 1);
    #2 rst = 0;
    #1;
    chk_idle_outputs("rstmid");
    chk("rstmid mem_address", LW'(mem_address), '0);
    chk("rstmid i_rdata", i_rdata, '0);
    @(posedge clk);
    #1;
    chk("rstmid held i_resp", LW'(i_resp), 0);
    rst = 1;
    mem_rdata = {32{8'h5A}};
    step(4'b1000);
    chk("after rst mem_read", LW'(mem_read), 1);
    chk("after rst mem_address", LW'(mem_address), LW'(AI));
    step(4'b1001);
    chk("after rst i_resp", LW'(i_resp), 1);
    chk("after rst i_rdata", i_rdata, {32{8'h5A}});
    step(4'b0000);
    chk_idle_outputs("after rst idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
